// File: rtl/bus_arb_pkg.sv
// -----------------------------------------------------------------------------
// bus_arb_pkg
// Shared types and constants for the two-master data bus arbiter.
//   arb_state_e : arbiter FSM state (IDLE, LOCK0, LOCK1)
//   master_id_t : identifies master 0 (CPU data port) or master 1 (DMA/blit)
//   NUM_MASTERS : number of masters sharing the data-side bus port
// -----------------------------------------------------------------------------
package bus_arb_pkg;

    localparam int NUM_MASTERS = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    typedef logic master_id_t;

endpackage : bus_arb_pkg

// File: rtl/bus_arb_rr.sv
// -----------------------------------------------------------------------------
// bus_arb_rr
// Purely combinational winner selection for the two-master bus arbiter.
//
// Ports:
//   req        in  [1:0] request vector, bit n = master n
//   last_owner in  1     master granted most recently
//   state      in  2     arbiter state (IDLE / LOCK0 / LOCK1)
//   gnt        out [1:0] one-hot (or zero) grant vector
//
// Configuration macro: BUS_ARB_ROUND_ROBIN_EN
//   defined     : a tie in arbitration goes to the master that is not last_owner
//   not defined : a tie always goes to master 0 (last_owner ignored)
// -----------------------------------------------------------------------------
module bus_arb_rr
    import bus_arb_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req,
    input  master_id_t             last_owner,
    input  arb_state_e             state,
    output logic [NUM_MASTERS-1:0] gnt
);

    logic [NUM_MASTERS-1:0] idle_gnt;

`ifndef BUS_ARB_ROUND_ROBIN_EN
    // Fixed-priority build keeps last_owner on the port for a uniform interface.
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

    // Arbitration used in IDLE and whenever the lock owner is not requesting.
    always_comb begin
        idle_gnt = '0;
        case (req)
            2'b01: idle_gnt = 2'b01;
            2'b10: idle_gnt = 2'b10;
            2'b11: begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
                idle_gnt = (last_owner == 1'b0) ? 2'b10 : 2'b01;
`else
                idle_gnt = 2'b01;
`endif
            end
            default: idle_gnt = '0;
        endcase
    end

    // A locking owner wins outright while it keeps requesting.
    always_comb begin
        gnt = idle_gnt;
        case (state)
            LOCK0:   gnt = req[0] ? 2'b01 : idle_gnt;
            LOCK1:   gnt = req[1] ? 2'b10 : idle_gnt;
            default: gnt = idle_gnt;
        endcase
    end

endmodule : bus_arb_rr

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Shares the single data-side bus port between the CPU data port (master 0)
// and the DMA/blit engine (master 1). One transfer is granted per cycle,
// combinationally; read data arriving one cycle later is routed back to the
// master that issued the read. A master may lock the bus for a short atomic
// burst; while the other master waits, a lock is held for at most MAX_HOLD
// consecutive grants.
//
// Parameters:
//   MAX_HOLD  maximum consecutive locked grants while the peer requests (>=1)
//
// Ports:
//   clk, reset_n                     clock (rising edge), async active-low reset
//   mN_req/addr/wdata/we/lock   in   master N request and attributes
//   mN_gnt                      out  transfer accepted this cycle
//   mN_rdata/mN_rvalid          out  read return, one cycle after a granted read
//   d_address/d_data_write      out  bus address / write data (0 when no grant)
//   d_write_enable/d_data_valid out  bus write strobe / transfer valid
//   d_data_read                 in   bus read data, valid the cycle after address
//
// Configuration macro: BUS_ARB_ROUND_ROBIN_EN (tie-break, see bus_arb_rr)
// -----------------------------------------------------------------------------
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_we,
    input  logic        m0_lock,
    output logic        m0_gnt,
    output logic [31:0] m0_rdata,
    output logic        m0_rvalid,

    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_we,
    input  logic        m1_lock,
    output logic        m1_gnt,
    output logic [31:0] m1_rdata,
    output logic        m1_rvalid,

    output logic [31:0] d_address,
    output logic [31:0] d_data_write,
    output logic        d_write_enable,
    output logic        d_data_valid,
    input  logic [31:0] d_data_read
);

    localparam int               HOLD_W     = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W:0]  MAX_HOLD_X = (HOLD_W + 1)'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MAX_HOLD);

    arb_state_e        state_q, state_d;
    master_id_t        last_owner_q, last_owner_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              rd_pend_q, rd_pend_d;
    master_id_t        rd_owner_q, rd_owner_d;

    logic [NUM_MASTERS-1:0] req_vec;
    logic [NUM_MASTERS-1:0] gnt_raw;
    logic [NUM_MASTERS-1:0] gnt;

    logic              granted;
    master_id_t        winner;
    logic              win_we;
    logic              win_lock;
    logic              other_req;
    logic [HOLD_W-1:0] hold_base;
    logic [HOLD_W:0]   hold_inc;
    logic              keep_lock;

    assign req_vec = {m1_req, m0_req};

    bus_arb_rr u_rr (
        .req        (req_vec),
        .last_owner (last_owner_q),
        .state      (state_q),
        .gnt        (gnt_raw)
    );

    // Grants are forced low while reset is asserted, even with requests high.
    assign gnt = reset_n ? gnt_raw : '0;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            hold_cnt_q   <= '0;
            rd_pend_q    <= 1'b0;
            rd_owner_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            hold_cnt_q   <= hold_cnt_d;
            rd_pend_q    <= rd_pend_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    // Next-state logic
    always_comb begin
        granted   = |gnt;
        winner    = gnt[1];
        win_we    = gnt[1] ? m1_we   : m0_we;
        win_lock  = gnt[1] ? m1_lock : m0_lock;
        other_req = gnt[1] ? m0_req  : m1_req;

        // The hold count only carries over while the same master keeps the lock;
        // a new owner starts its burst from zero.
        hold_base = ((state_q == LOCK0 && gnt[0]) || (state_q == LOCK1 && gnt[1]))
                    ? hold_cnt_q : '0;
        hold_inc  = {1'b0, hold_base} + (HOLD_W + 1)'(1);

        // Lock is honoured unconditionally with an idle peer, otherwise only
        // until this grant would reach MAX_HOLD.
        keep_lock = win_lock && ((hold_inc < MAX_HOLD_X) || !other_req);

        state_d      = IDLE;
        hold_cnt_d   = '0;
        last_owner_d = last_owner_q;
        rd_pend_d    = granted && !win_we;
        rd_owner_d   = granted ? winner : rd_owner_q;

        if (granted) begin
            last_owner_d = winner;
            if (keep_lock) begin
                state_d    = winner ? LOCK1 : LOCK0;
                hold_cnt_d = (hold_inc > MAX_HOLD_X) ? HOLD_SAT : hold_inc[HOLD_W-1:0];
            end
        end
    end

    // Output logic
    always_comb begin
        m0_gnt         = gnt[0];
        m1_gnt         = gnt[1];
        d_data_valid   = |gnt;
        d_address      = '0;
        d_data_write   = '0;
        d_write_enable = 1'b0;
        if (gnt[0]) begin
            d_address      = m0_addr;
            d_data_write   = m0_wdata;
            d_write_enable = m0_we;
        end else if (gnt[1]) begin
            d_address      = m1_addr;
            d_data_write   = m1_wdata;
            d_write_enable = m1_we;
        end

        m0_rvalid = reset_n && rd_pend_q && (rd_owner_q == 1'b0);
        m1_rvalid = reset_n && rd_pend_q && (rd_owner_q == 1'b1);
        m0_rdata  = m0_rvalid ? d_data_read : '0;
        m1_rdata  = m1_rvalid ? d_data_read : '0;
    end

endmodule : bus_arbiter

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

    logic        clk;
    logic        reset_n;
    logic        m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [31:0] d_address, d_data_write, d_data_read;
    logic        d_write_enable, d_data_valid;

    int checks;
    int errors;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    bus_arbiter #(.MAX_HOLD(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .m0_req         (m0_req),
        .m0_addr        (m0_addr),
        .m0_wdata       (m0_wdata),
        .m0_we          (m0_we),
        .m0_lock        (m0_lock),
        .m0_gnt         (m0_gnt),
        .m0_rdata       (m0_rdata),
        .m0_rvalid      (m0_rvalid),
        .m1_req         (m1_req),
        .m1_addr        (m1_addr),
        .m1_wdata       (m1_wdata),
        .m1_we          (m1_we),
        .m1_lock        (m1_lock),
        .m1_gnt         (m1_gnt),
        .m1_rdata       (m1_rdata),
        .m1_rvalid      (m1_rvalid),
        .d_address      (d_address),
        .d_data_write   (d_data_write),
        .d_write_enable (d_write_enable),
        .d_data_valid   (d_data_valid),
        .d_data_read    (d_data_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        m0_req = 0; m0_addr = 0; m0_wdata = 0; m0_we = 0; m0_lock = 0;
        m1_req = 0; m1_addr = 0; m1_wdata = 0; m1_we = 0; m1_lock = 0;
        d_data_read = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        m0_req = 1; m0_addr = 32'h55; m0_wdata = 32'h66; m0_we = 1;
        m1_req = 1; m1_addr = 32'h77; m1_we = 1;
        d_data_read = 32'hFFFF_FFFF;
        #1;
        checks++;
        if ({m1_gnt, m0_gnt} !== 2'b00) begin
            errors++; $display("FAIL reset_gnt got %b exp 00", {m1_gnt, m0_gnt});
        end
        checks++;
        if ({d_data_valid, d_write_enable, m0_rvalid, m1_rvalid} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl got %b exp 0000",
                               {d_data_valid, d_write_enable, m0_rvalid, m1_rvalid});
        end
        checks++;
        if ({d_address, d_data_write, m0_rdata, m1_rdata} !== 128'h0) begin
            errors++; $display("FAIL reset_data got %h %h %h %h exp 0",
                               d_address, d_data_write, m0_rdata, m1_rdata);
        end
        @(negedge clk);
        idle_inputs();
        reset_n = 1'b1;
    endtask

    task automatic test_single_read();
        do_reset();
        @(negedge clk);
        m0_req = 1; m0_addr = 32'h0000_0010; m0_we = 0;
        #1;
        checks++;
        if ({m1_gnt, m0_gnt, d_data_valid, d_write_enable} !== 4'b0110) begin
            errors++; $display("FAIL single_gnt got %b exp 0110",
                               {m1_gnt, m0_gnt, d_data_valid, d_write_enable});
        end
        checks++;
        if (d_address !== 32'h0000_0010) begin
            errors++; $display("FAIL single_addr got %h exp 00000010", d_address);
        end
        @(negedge clk);
        m0_req = 0;
        d_data_read = 32'hDEAD_BEEF;
        #1;
        checks++;
        if ({m0_rvalid, m1_rvalid} !== 2'b10) begin
            errors++; $display("FAIL single_rvalid got %b exp 10", {m0_rvalid, m1_rvalid});
        end
        checks++;
        if (m0_rdata !== 32'hDEAD_BEEF || m1_rdata !== 32'h0) begin
            errors++; $display("FAIL single_rdata got %h/%h exp deadbeef/0", m0_rdata, m1_rdata);
        end
        checks++;
        if ({d_data_valid, d_address} !== 33'h0) begin
            errors++; $display("FAIL single_nogrant got %b %h exp 0 0", d_data_valid, d_address);
        end
        @(negedge clk);
        d_data_read = 32'h0;
        #1;
        checks++;
        if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
            errors++; $display("FAIL single_rvalid_end got %b exp 00", {m0_rvalid, m1_rvalid});
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_g;
        logic       prev_w;
        logic [31:0] rd;
        do_reset();
        prev_w = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            m0_req = (i < 6); m0_addr = 32'h100; m0_we = 0;
            m1_req = (i < 6); m1_addr = 32'h200; m1_we = 0;
            rd = 32'hA000_0000 | i;
            d_data_read = rd;
            #1;
            if (i < 6) begin
                exp_g = (RR && (i % 2 == 1)) ? 2'b10 : 2'b01;
                checks++;
                if ({m1_gnt, m0_gnt} !== exp_g) begin
                    errors++; $display("FAIL b2b_gnt[%0d] got %b exp %b", i, {m1_gnt, m0_gnt}, exp_g);
                end
                checks++;
                if (d_address !== (exp_g[1] ? 32'h200 : 32'h100)) begin
                    errors++; $display("FAIL b2b_addr[%0d] got %h", i, d_address);
                end
            end
            if (i > 0) begin
                checks++;
                if ({m1_rvalid, m0_rvalid} !== (prev_w ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL b2b_rvalid[%0d] got %b exp owner %0d",
                                       i, {m1_rvalid, m0_rvalid}, prev_w);
                end
                checks++;
                if ((prev_w ? m1_rdata : m0_rdata) !== rd
                    || (prev_w ? m0_rdata : m1_rdata) !== 32'h0) begin
                    errors++; $display("FAIL b2b_rdata[%0d] got %h/%h exp %h to %0d",
                                       i, m0_rdata, m1_rdata, rd, prev_w);
                end
            end
            prev_w = RR && (i % 2 == 1);
        end
    endtask

    task automatic test_lock_max_hold();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            m1_req = 1; m1_we = 1; m1_lock = 1;
            m1_addr = 32'h300 + i; m1_wdata = 32'hB000_0000 + i;
            m0_req = (i > 0); m0_addr = 32'h400; m0_we = 0;
            #1;
            checks++;
            if ({m1_gnt, m0_gnt} !== ((i < 4) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL lock_gnt[%0d] got %b exp %b",
                                   i, {m1_gnt, m0_gnt}, (i < 4) ? 2'b10 : 2'b01);
            end
            checks++;
            if (d_write_enable !== (i < 4)) begin
                errors++; $display("FAIL lock_we[%0d] got %b exp %b", i, d_write_enable, (i < 4));
            end
            if (i < 4) begin
                checks++;
                if (d_data_write !== 32'hB000_0000 + i) begin
                    errors++; $display("FAIL lock_wdata[%0d] got %h", i, d_data_write);
                end
            end
            if (i > 0) begin
                checks++;
                if (m1_rvalid !== 1'b0) begin
                    errors++; $display("FAIL lock_wr_rvalid[%0d] got %b exp 0", i, m1_rvalid);
                end
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_lock_idle_peer();
        logic [1:0] exp_g;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            m0_req = 1; m0_we = 1; m0_lock = 1;
            m0_addr = 32'h500 + i; m0_wdata = 32'h1000 + i;
            m1_req = (i >= 10); m1_addr = 32'h600; m1_we = 0;
            #1;
            // Saturated lock is still honoured on the first contested grant, then released.
            exp_g = (i == 11 && RR) ? 2'b10 : 2'b01;
            checks++;
            if ({m1_gnt, m0_gnt} !== exp_g) begin
                errors++; $display("FAIL idle_peer_gnt[%0d] got %b exp %b", i, {m1_gnt, m0_gnt}, exp_g);
            end
            if (i < 10) begin
                checks++;
                if (d_data_write !== 32'h1000 + i) begin
                    errors++; $display("FAIL idle_peer_wdata[%0d] got %h", i, d_data_write);
                end
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        @(negedge clk);
        m0_req = 1; m0_addr = 32'h40; m0_we = 0;
        #1;
        checks++;
        if (m0_gnt !== 1'b1) begin
            errors++; $display("FAIL midrst_gnt got %b exp 1", m0_gnt);
        end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        m1_req = 1; m1_we = 1; m1_addr = 32'h80; m1_wdata = 32'h99;
        d_data_read = 32'h1234_5678;
        #1;
        checks++;
        if ({m0_rvalid, m1_rvalid, m0_gnt, m1_gnt, d_data_valid, d_write_enable} !== 6'b0) begin
            errors++; $display("FAIL midrst_ctrl got %b exp 000000",
                               {m0_rvalid, m1_rvalid, m0_gnt, m1_gnt, d_data_valid, d_write_enable});
        end
        checks++;
        if ({m0_rdata, d_address, d_data_write} !== 96'h0) begin
            errors++; $display("FAIL midrst_data got %h %h %h exp 0", m0_rdata, d_address, d_data_write);
        end
        @(negedge clk);
        reset_n = 1'b1;
        m0_req = 1; m0_we = 0; m0_addr = 32'h44;
        m1_req = 1; m1_we = 0; m1_addr = 32'h88;
        #1;
        checks++;
        if ({m1_gnt, m0_gnt} !== 2'b01) begin
            errors++; $display("FAIL midrst_tie got %b exp 01", {m1_gnt, m0_gnt});
        end
        checks++;
        if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
            errors++; $display("FAIL midrst_norvalid got %b exp 00", {m0_rvalid, m1_rvalid});
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_cancel_lock();
        do_reset();
        @(negedge clk);
        m0_req = 1; m0_we = 1; m0_lock = 1; m0_addr = 32'h700;
        #1;
        checks++;
        if ({m1_gnt, m0_gnt} !== 2'b01) begin
            errors++; $display("FAIL cancel_c0 got %b exp 01", {m1_gnt, m0_gnt});
        end
        @(negedge clk);
        m1_req = 1; m1_we = 0; m1_lock = 0; m1_addr = 32'h800;
        #1;
        checks++;
        if ({m1_gnt, m0_gnt} !== 2'b01) begin
            errors++; $display("FAIL cancel_c1 got %b exp 01", {m1_gnt, m0_gnt});
        end
        @(negedge clk);
        m0_req = 0;
        #1;
        checks++;
        if ({m1_gnt, m0_gnt} !== 2'b10 || d_address !== 32'h800) begin
            errors++; $display("FAIL cancel_c2 got %b %h exp 10 00000800", {m1_gnt, m0_gnt}, d_address);
        end
        @(negedge clk);
        m0_req = 1; m0_we = 0; m0_lock = 0;
        #1;
        checks++;
        if ({m1_gnt, m0_gnt} !== 2'b01) begin
            errors++; $display("FAIL cancel_c3 got %b exp 01", {m1_gnt, m0_gnt});
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single_read();
        test_back_to_back();
        test_lock_max_hold();
        test_lock_idle_peer();
        test_reset_mid_read();
        test_cancel_lock();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bus_arbiter
